// File: rtl/bure_stage_id_q.sv
// bure_stage_id_q: RV32I decode stage feeding a DEPTH-entry decoded-instruction
// queue between fetch and execute. Each accepted fetch word is decoded and
// queued. Both sides use valid/ready handshakes, and i_flush drops all
// queued work.
// Optional feature: define BURE_ID_ILLEGAL_CHECK_EN to flag opcodes outside
// the RV32I base. When it is set, those words lose rd_wen and op-class flags.
module bure_stage_id_q #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_instr_valid,
    output logic                    o_instr_ready,
    input  logic [INSTR_WIDTH-1:0]  i_instr,
    input  logic [ADDR_WIDTH-1:0]   i_instr_addr,
    output logic                    o_decode_valid,
    input  logic                    i_decode_ready,
    output logic [ADDR_WIDTH-1:0]   o_pc,
    output logic [2:0]              o_funct3,
    output logic [6:0]              o_funct7,
    output logic [4:0]              o_rs1_addr,
    output logic [4:0]              o_rs2_addr,
    output logic [4:0]              o_rd_addr,
    output logic                    o_rd_wen,
    output logic [DATA_WIDTH-1:0]   o_imm,
    output logic [ADDR_WIDTH-1:0]   o_target,
    output logic                    o_is_imm_op,
    output logic                    o_is_jump_op,
    output logic                    o_is_branch_op,
    output logic                    o_is_load_op,
    output logic                    o_is_store_op,
    output logic                    o_illegal,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
`ifdef BURE_ID_ILLEGAL_CHECK_EN
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
`endif

    // One queue entry: everything execute needs, already decoded.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [6:0]            funct7;
        logic [2:0]            funct3;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic                  rd_wen;
        logic [DATA_WIDTH-1:0] imm;
        logic [ADDR_WIDTH-1:0] target;
        logic                  is_imm;
        logic                  is_jump;
        logic                  is_branch;
        logic                  is_load;
        logic                  is_store;
        logic                  illegal;
    } entry_t;

    logic [31:0]      word;
    logic [31:0]      imm32;
    logic             writes_rd;
    entry_t           dec_raw;
    entry_t           dec;
    entry_t           head;
    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign word = i_instr[31:0];

    // Full decode of the incoming fetch word: fields, immediate, class, target.
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        dec_raw        = '0;
        imm32          = '0;
        writes_rd      = 1'b0;
        dec_raw.pc     = i_instr_addr;
        dec_raw.funct7 = word[31:25];
        dec_raw.rs2    = word[24:20];
        dec_raw.rs1    = word[19:15];
        dec_raw.funct3 = word[14:12];
        dec_raw.rd     = word[11:7];
        case (word[6:0])
            OPC_LUI, OPC_AUIPC: begin
                imm32     = {word[31:12], 12'b0};
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                imm32           = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
                writes_rd       = 1'b1;
                dec_raw.is_jump = 1'b1;
            end
            OPC_JALR: begin
                imm32           = {{20{word[31]}}, word[31:20]};
                writes_rd       = 1'b1;
                dec_raw.is_jump = 1'b1;
            end
            OPC_BRANCH: begin
                imm32             = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
                dec_raw.is_branch = 1'b1;
            end
            OPC_LOAD: begin
                imm32           = {{20{word[31]}}, word[31:20]};
                writes_rd       = 1'b1;
                dec_raw.is_load = 1'b1;
            end
            OPC_STORE: begin
                imm32            = {{20{word[31]}}, word[31:25], word[11:7]};
                dec_raw.is_store = 1'b1;
            end
            OPC_OP_IMM: begin
                imm32          = {{20{word[31]}}, word[31:20]};
                writes_rd      = 1'b1;
                dec_raw.is_imm = 1'b1;
            end
            OPC_OP: writes_rd = 1'b1;
            default: ;
        endcase
        dec_raw.rd_wen = writes_rd && (word[11:7] != 5'd0);
        dec_raw.imm    = DATA_WIDTH'(signed'(imm32));
        dec_raw.target = i_instr_addr + ADDR_WIDTH'(signed'(imm32));
    end

`ifdef BURE_ID_ILLEGAL_CHECK_EN
    // Opcodes outside the RV32I base are flagged and stripped of side effects.
    always_comb begin
        dec = dec_raw;
        case (word[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: dec.illegal = 1'b0;
            default: begin
                dec.illegal   = 1'b1;
                dec.rd_wen    = 1'b0;
                dec.is_imm    = 1'b0;
                dec.is_jump   = 1'b0;
                dec.is_branch = 1'b0;
                dec.is_load   = 1'b0;
                dec.is_store  = 1'b0;
            end
        endcase
    end
`else
    assign dec = dec_raw;
`endif

    // Ready/valid come only from the registered count, so the two sides never combine.
    assign o_instr_ready  = (count < CNT_W'(DEPTH));
    assign o_decode_valid = (count != '0);
    assign push           = i_instr_valid && o_instr_ready && !i_flush;
    assign pop            = o_decode_valid && i_decode_ready && !i_flush;

    // Queue bookkeeping: reset beats flush, and flush beats push and pop.
    // NOTE: state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Entry storage is written on push only.
    // NOTE: storage has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // Head entry, with the whole payload held at zero while the queue is empty.
    always_comb begin
        head = '0;
        if (o_decode_valid) head = mem[rd_ptr];
    end

    assign o_pc           = head.pc;
    assign o_funct3       = head.funct3;
    assign o_funct7       = head.funct7;
    assign o_rs1_addr     = head.rs1;
    assign o_rs2_addr     = head.rs2;
    assign o_rd_addr      = head.rd;
    assign o_rd_wen       = head.rd_wen;
    assign o_imm          = head.imm;
    assign o_target       = head.target;
    assign o_is_imm_op    = head.is_imm;
    assign o_is_jump_op   = head.is_jump;
    assign o_is_branch_op = head.is_branch;
    assign o_is_load_op   = head.is_load;
    assign o_is_store_op  = head.is_store;
    assign o_illegal      = head.illegal;
    assign o_count        = count;

endmodule

// File: tb/tb_bure_stage_id_q.sv
// Testbench for bure_stage_id_q. It applies a decode vector table and hand
// sequences for the full, flush and back-to-back cases. It then runs random
// traffic against a queue-based reference model.
module tb_bure_stage_id_q;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef BURE_ID_ILLEGAL_CHECK_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] imm;
        logic [31:0] target;
        logic [4:0]  flags;   // {imm, jump, branch, load, store}
        logic        illegal;
    } payload_t;

    typedef struct packed {
        logic             valid;
        logic             ready;
        logic [CNT_W-1:0] count;
        payload_t         pay;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        payload_t    exp;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst, i_flush, i_instr_valid, i_decode_ready;
    logic [31:0] i_instr, i_instr_addr;
    logic        o_instr_ready, o_decode_valid, o_rd_wen, o_illegal;
    logic [31:0] o_pc, o_imm, o_target;
    logic [2:0]  o_funct3;
    logic [6:0]  o_funct7;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic        o_is_imm_op, o_is_jump_op, o_is_branch_op, o_is_load_op, o_is_store_op;
    logic [CNT_W-1:0] o_count;

    int checks = 0;
    int errors = 0;
    payload_t mq[$];
    vec_t vecs[10];

    bure_stage_id_q #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
        .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
        .i_instr(i_instr), .i_instr_addr(i_instr_addr),
        .o_decode_valid(o_decode_valid), .i_decode_ready(i_decode_ready),
        .o_pc(o_pc), .o_funct3(o_funct3), .o_funct7(o_funct7),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
        .o_rd_wen(o_rd_wen), .o_imm(o_imm), .o_target(o_target),
        .o_is_imm_op(o_is_imm_op), .o_is_jump_op(o_is_jump_op),
        .o_is_branch_op(o_is_branch_op), .o_is_load_op(o_is_load_op),
        .o_is_store_op(o_is_store_op), .o_illegal(o_illegal), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode computed straight from the ISA immediate rules.
    function automatic payload_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        payload_t   p;
        int         imm;
        logic [6:0] opc;
        opc      = w[6:0];
        p        = '0;
        imm      = 0;
        p.pc     = pc;
        p.funct3 = w[14:12];
        p.funct7 = w[31:25];
        p.rs1    = w[19:15];
        p.rs2    = w[24:20];
        p.rd     = w[11:7];
        case (opc)
            7'h13, 7'h03, 7'h67: imm = $signed(w) >>> 20;
            7'h23: imm = (($signed(w) >>> 25) <<< 5) | int'(w[11:7]);
            7'h63: imm = (($signed(w) >>> 31) <<< 12) | (int'(w[7]) << 11)
                         | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1);
            7'h37, 7'h17: imm = int'(w & 32'hFFFF_F000);
            7'h6F: imm = (($signed(w) >>> 31) <<< 20) | (int'(w[19:12]) << 12)
                         | (int'(w[20]) << 11) | (int'(w[30:21]) << 1);
            default: imm = 0;
        endcase
        p.imm    = 32'(imm);
        p.target = pc + 32'(imm);
        p.rd_wen = (opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33}) && (p.rd != 0);
        p.flags  = {opc == 7'h13, opc inside {7'h6F, 7'h67}, opc == 7'h63, opc == 7'h03, opc == 7'h23};
        if (ILL_EN && !(opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                    7'h13, 7'h33, 7'h0F, 7'h73})) begin
            p.illegal = 1'b1;
            p.rd_wen  = 1'b0;
            p.flags   = '0;
        end
        return p;
    endfunction

    // Reference queue advanced once per rising edge with the applied inputs.
    task automatic model_clock();
        bit do_push, do_pop;
        if (i_rst || i_flush) begin
            mq.delete();
        end else begin
            do_push = i_instr_valid && (mq.size() < DEPTH);
            do_pop  = i_decode_ready && (mq.size() != 0);
            if (do_pop) mq.delete(0);
            if (do_push) mq.push_back(ref_decode(i_instr, i_instr_addr));
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o       = '0;
        o.valid = (mq.size() != 0);
        o.ready = (mq.size() < DEPTH);
        o.count = CNT_W'(mq.size());
        if (mq.size() != 0) o.pay = mq[0];
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.valid       = o_decode_valid;
        o.ready       = o_instr_ready;
        o.count       = o_count;
        o.pay.pc      = o_pc;
        o.pay.funct3  = o_funct3;
        o.pay.funct7  = o_funct7;
        o.pay.rs1     = o_rs1_addr;
        o.pay.rs2     = o_rs2_addr;
        o.pay.rd      = o_rd_addr;
        o.pay.rd_wen  = o_rd_wen;
        o.pay.imm     = o_imm;
        o.pay.target  = o_target;
        o.pay.flags   = {o_is_imm_op, o_is_jump_op, o_is_branch_op, o_is_load_op, o_is_store_op};
        o.pay.illegal = o_illegal;
        return o;
    endfunction

    function automatic payload_t mk_pay(input logic [31:0] pc, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd,
                                        input logic wen, input logic [31:0] imm,
                                        input logic [31:0] tgt, input logic [4:0] flags,
                                        input logic ill);
        payload_t p;
        p.pc = pc; p.funct3 = f3; p.funct7 = f7; p.rs1 = rs1; p.rs2 = rs2; p.rd = rd;
        p.rd_wen = wen; p.imm = imm; p.target = tgt; p.flags = flags; p.illegal = ill;
        return p;
    endfunction

    task automatic drive(input logic rst, input logic flush, input logic valid,
                         input logic [31:0] instr, input logic [31:0] addr, input logic dready);
        i_rst          = rst;
        i_flush        = flush;
        i_instr_valid  = valid;
        i_instr        = instr;
        i_instr_addr   = addr;
        i_decode_ready = dready;
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge i_clk);
        model_clock();
        @(negedge i_clk);
    endtask

    initial begin
        obs_t       reset_obs;
        obs_t       exp;
        logic [6:0] opc_tab [11];
        logic [31:0] r;
        int         k;
        bit         rst_now;

        vecs[0] = '{32'hFFF00293, 32'h100, mk_pay(32'h100, 3'd0, 7'h7F, 5'd0, 5'd31, 5'd5, 1'b1, 32'hFFFFFFFF, 32'h000000FF, 5'b10000, 1'b0)};
        vecs[1] = '{32'h008000EF, 32'h200, mk_pay(32'h200, 3'd0, 7'h00, 5'd0, 5'd8, 5'd1, 1'b1, 32'h8, 32'h208, 5'b01000, 1'b0)};
        vecs[2] = '{32'hFE208EE3, 32'h300, mk_pay(32'h300, 3'd0, 7'h7F, 5'd1, 5'd2, 5'd29, 1'b0, 32'hFFFFFFFC, 32'h2FC, 5'b00100, 1'b0)};
        vecs[3] = '{32'h12345037, 32'h400, mk_pay(32'h400, 3'd5, 7'h09, 5'd8, 5'd3, 5'd0, 1'b0, 32'h12345000, 32'h12345400, 5'b00000, 1'b0)};
        vecs[4] = '{32'hFE20AC23, 32'h500, mk_pay(32'h500, 3'd2, 7'h7F, 5'd1, 5'd2, 5'd24, 1'b0, 32'hFFFFFFF8, 32'h4F8, 5'b00001, 1'b0)};
        vecs[5] = '{32'h0101A503, 32'h600, mk_pay(32'h600, 3'd2, 7'h00, 5'd3, 5'd16, 5'd10, 1'b1, 32'h10, 32'h610, 5'b00010, 1'b0)};
        vecs[6] = '{32'h00008067, 32'h700, mk_pay(32'h700, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 1'b0, 32'h0, 32'h700, 5'b01000, 1'b0)};
        vecs[7] = '{32'h002081B3, 32'h800, mk_pay(32'h800, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0, 32'h800, 5'b00000, 1'b0)};
        vecs[8] = '{32'hFFFFF397, 32'h900, mk_pay(32'h900, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd7, 1'b1, 32'hFFFFF000, 32'hFFFFF900, 5'b00000, 1'b0)};
        vecs[9] = '{32'h00000000, 32'hA00, mk_pay(32'hA00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'hA00, 5'b00000, ILL_EN)};

        opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

        reset_obs       = '0;
        reset_obs.ready = 1'b1;

        // Reset state.
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        @(negedge i_clk);
        tick();
        tick();
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        check("reset_state", dut_obs(), reset_obs);

        // Decode table: each word pushed into an empty queue, seen next cycle, then popped.
        for (int v = 0; v < 10; v++) begin
            drive(0, 0, 1, vecs[v].instr, vecs[v].pc, 0);
            tick();
            exp       = '0;
            exp.valid = 1'b1;
            exp.ready = 1'b1;
            exp.count = CNT_W'(1);
            exp.pay   = vecs[v].exp;
            check($sformatf("decode_vec%0d", v), dut_obs(), exp);
            drive(0, 0, 0, 32'h0, 32'h0, 1);
            tick();
        end
        check("table_drained", dut_obs(), reset_obs);

        // Back-to-back pushes: jal then beq, popped in order.
        drive(0, 0, 1, 32'h008000EF, 32'h200, 0);
        tick();
        drive(0, 0, 1, 32'hFE208EE3, 32'h300, 0);
        tick();
        check("b2b_count", o_count, 2);
        check("b2b_head_jal", {o_target, o_is_jump_op, o_rd_addr}, {32'h208, 1'b1, 5'd1});
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        tick();
        check("b2b_head_beq", {o_target, o_is_branch_op, o_rd_wen, o_imm},
              {32'h2FC, 1'b1, 1'b0, 32'hFFFFFFFC});
        tick();
        check("b2b_empty", o_decode_valid, 0);

        // Full queue: third word is held until a pop frees a slot.
        drive(0, 0, 1, 32'h002081B3, 32'h1000, 0);
        tick();
        drive(0, 0, 1, 32'h0101A503, 32'h1004, 0);
        tick();
        check("full_ready_count", {o_instr_ready, o_count}, {1'b0, 2'd2});
        drive(0, 0, 1, 32'h00008067, 32'h1008, 0);
        tick();
        check("full_held", {o_count, o_pc}, {2'd2, 32'h1000});
        drive(0, 0, 1, 32'h00008067, 32'h1008, 1);
        tick();
        check("full_pop_no_passthru", {o_count, o_instr_ready, o_pc}, {2'd1, 1'b1, 32'h1004});
        drive(0, 0, 1, 32'h00008067, 32'h1008, 0);
        tick();
        check("full_third_accepted", o_count, 2);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        tick();
        check("full_order", {o_pc, o_is_jump_op}, {32'h1008, 1'b1});
        drive(0, 0, 1, 32'hFE20AC23, 32'h100C, 0);
        tick();
        check("refill_count", o_count, 2);

        // Flush with push and pop requested: everything dropped.
        drive(0, 1, 1, 32'h0101A503, 32'h1010, 1);
        tick();
        check("flush_state", dut_obs(), reset_obs);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        tick();
        check("flush_idle", dut_obs(), reset_obs);

        // Sustained push+pop at one entry; head advances every cycle.
        drive(0, 0, 1, 32'h008000EF, 32'h2000, 0);
        tick();
        check("post_flush_head", {o_count, o_pc}, {2'd1, 32'h2000});
        drive(0, 0, 1, 32'h002081B3, 32'h2004, 1);
        tick();
        check("stream_1", {o_count, o_pc, o_rd_addr}, {2'd1, 32'h2004, 5'd3});
        drive(0, 0, 1, 32'hFFF00293, 32'h2008, 1);
        tick();
        check("stream_2", {o_count, o_pc, o_target}, {2'd1, 32'h2008, 32'h2007});
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        tick();
        check("stream_drained", dut_obs(), reset_obs);

        // Random traffic against the reference queue, with reset pulses mid-run.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            check("rand_cycle", dut_obs(), model_obs());
            r       = $urandom();
            k       = $urandom_range(0, 11);
            rst_now = (cyc == 4000) || (cyc == 4001) || ($urandom_range(0, 999) == 0);
            drive(rst_now, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
                  (k == 11) ? r : {r[31:7], opc_tab[k]}, $urandom(), ($urandom_range(0, 99) < 60));
            tick();
            if (rst_now) check("rand_rst_count", o_count, 0);
        end
        check("rand_final", dut_obs(), model_obs());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
